// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared op codes, FSM states and memory map constants
// for the load/store unit's data RAM controller.
package lsu_mem_ctrl_pkg;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LBU = 3'b001;
    localparam logic [2:0] OP_LH  = 3'b010;
    localparam logic [2:0] OP_LHU = 3'b011;
    localparam logic [2:0] OP_LW  = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    localparam logic [31:0] DATA_MEM_BASE = 32'h0001_0000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    function automatic logic is_store(input logic [2:0] op);
        return op[2] & (|op[1:0]);
    endfunction

endpackage

// File: rtl/lsu_lane_steer.sv
// Big-endian byte-lane steering, load extension and
// alignment check for one load/store operation.
module lsu_lane_steer
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  a,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wlane,
    output logic [31:0] rext,
    output logic        misalign
);

    logic        st;
    logic        is_byte;
    logic        is_half;
    logic [7:0]  b;
    logic [15:0] h;

    assign st      = is_store(op);
    assign is_byte = (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
    assign is_half = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);

    // lane 0 (a=0) is the most significant byte
    assign b = rdata[{~a, 3'b000} +: 8];
    assign h = a[1] ? rdata[15:0] : rdata[31:16];

    always_comb begin
        sel      = 4'b1111;
        wlane    = wdata;
        rext     = rdata;
        misalign = 1'b0;
        unique case (1'b1)
            is_byte: begin
                rext = op[0] ? {24'b0, b} : {{24{b[7]}}, b};
                if (st) begin
                    sel   = 4'b1000 >> a;
                    wlane = {4{wdata[7:0]}};
                end
            end
            is_half: begin
                misalign = a[0];
                rext     = op[0] ? {16'b0, h} : {{16{h[15]}}, h};
                if (st) begin
                    sel   = a[1] ? 4'b0011 : 4'b1100;
                    wlane = {2{wdata[15:0]}};
                end
            end
            default: begin
                misalign = |a;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Data RAM load/store initiator: one request at a time,
// fixed two-cycle response latency including error responses.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DATA_MEM_BASE,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_op_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_misalign_o,
    output logic        resp_range_o,
    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i
);

    localparam logic [31:0] LIMIT = BASE_ADDR + 32'(DEPTH_WORDS) * 32'd4;

    state_e      state_q, state_d;
    logic        hold_q, hold_d;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        mis_q;
    logic        rng_q;
    logic [31:0] rdata_q;

    logic        idle;
    logic        in_acc;
    logic        accept;
    logic        in_rng;
    logic [2:0]  st_op;
    logic [1:0]  st_a;
    logic [3:0]  st_sel;
    logic [31:0] st_wlane;
    logic [31:0] st_rext;
    logic        st_mis;

    assign idle   = (state_q == S_IDLE);
    assign in_acc = (state_q == S_ACCESS);
    assign accept = idle && req_valid_i;
    assign in_rng = (req_addr_i >= BASE_ADDR) && (req_addr_i < LIMIT);

    // in IDLE the steer checks the incoming request for alignment
    assign st_op = idle ? req_op_i : op_q;
    assign st_a  = idle ? req_addr_i[1:0] : addr_q[1:0];

    lsu_lane_steer u_steer (
        .op       (st_op),
        .a        (st_a),
        .wdata    (wdata_q),
        .rdata    (ram_data_i),
        .sel      (st_sel),
        .wlane    (st_wlane),
        .rext     (st_rext),
        .misalign (st_mis)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            hold_q  <= 1'b0;
            op_q    <= 3'b0;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
            mis_q   <= 1'b0;
            rng_q   <= 1'b0;
            rdata_q <= 32'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            if (accept) begin
                op_q    <= req_op_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                mis_q   <= st_mis;
                rng_q   <= ~in_rng;
                rdata_q <= 32'b0;
            end
            if (in_acc && !is_store(op_q)) begin
                rdata_q <= st_rext;
            end
        end
    end

    // error path waits one cycle in RESP to match the RAM latency
    always_comb begin
        state_d = state_q;
        hold_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    if (st_mis || !in_rng) begin
                        state_d = S_RESP;
                        hold_d  = 1'b1;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: state_d = S_RESP;
            S_RESP: begin
                if (!hold_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready_o     = idle;
    assign resp_valid_o    = (state_q == S_RESP) && !hold_q;
    assign resp_rdata_o    = resp_valid_o ? rdata_q : 32'b0;
    assign resp_misalign_o = resp_valid_o && mis_q;
    assign resp_range_o    = resp_valid_o && rng_q;

    assign ram_ce_o   = in_acc;
    assign ram_we_o   = in_acc && is_store(op_q);
    assign ram_addr_o = in_acc ? {addr_q[31:2], 2'b00} : 32'b0;
    assign ram_sel_o  = in_acc ? st_sel : 4'b0;
    assign ram_data_o = ram_we_o ? st_wlane : 32'b0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a byte-select
// data RAM model behind the RAM port.
module tb_lsu_mem_ctrl;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LBU = 3'b001;
    localparam logic [2:0] LH  = 3'b010;
    localparam logic [2:0] LHU = 3'b011;
    localparam logic [2:0] LW  = 3'b100;
    localparam logic [2:0] SB  = 3'b101;
    localparam logic [2:0] SH  = 3'b110;
    localparam logic [2:0] SW  = 3'b111;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_mis;
    logic        resp_rng;
    logic        ram_ce;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [3:0]  ram_sel;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] mem [0:1023];
    logic [31:0] off;
    logic [9:0]  idx;

    int checks = 0;
    int failures = 0;

    logic        a_ce, a_we, a_rv;
    logic [3:0]  a_sel;
    logic [31:0] a_addr, a_data;
    logic        r_v, r_mis, r_rng, r_ce;
    logic [31:0] r_data;

    always #5 clk = ~clk;

    lsu_mem_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_op_i        (req_op),
        .req_addr_i      (req_addr),
        .req_wdata_i     (req_wdata),
        .resp_valid_o    (resp_valid),
        .resp_rdata_o    (resp_rdata),
        .resp_misalign_o (resp_mis),
        .resp_range_o    (resp_rng),
        .ram_ce_o        (ram_ce),
        .ram_we_o        (ram_we),
        .ram_addr_o      (ram_addr),
        .ram_sel_o       (ram_sel),
        .ram_data_o      (ram_wdata),
        .ram_data_i      (ram_rdata)
    );

    assign off       = ram_addr - 32'h0001_0000;
    assign idx       = off[11:2];
    assign ram_rdata = mem[idx];

    always @(posedge clk) begin
        if (ram_ce && ram_we) begin
            if (ram_sel[3]) mem[idx][31:24] <= ram_wdata[31:24];
            if (ram_sel[2]) mem[idx][23:16] <= ram_wdata[23:16];
            if (ram_sel[1]) mem[idx][15:8]  <= ram_wdata[15:8];
            if (ram_sel[0]) mem[idx][7:0]   <= ram_wdata[7:0];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // accept at edge N, snapshot ACCESS (N+1) and response (N+2)
    task automatic xact(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        a_ce   = ram_ce;
        a_we   = ram_we;
        a_sel  = ram_sel;
        a_addr = ram_addr;
        a_data = ram_wdata;
        a_rv   = resp_valid;
        @(negedge clk);
        r_v    = resp_valid;
        r_data = resp_rdata;
        r_mis  = resp_mis;
        r_rng  = resp_rng;
        r_ce   = ram_ce;
    endtask

    initial begin
        #2;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rvalid", {31'b0, resp_valid}, 32'd0);
        check("rst_ce", {31'b0, ram_ce}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        xact(SW, 32'h0001_0004, 32'h1122_3344);
        check("sw_ce", {31'b0, a_ce}, 32'd1);
        check("sw_we", {31'b0, a_we}, 32'd1);
        check("sw_sel", {28'b0, a_sel}, 32'hF);
        check("sw_addr", a_addr, 32'h0001_0004);
        check("sw_data", a_data, 32'h1122_3344);
        check("sw_early_rv", {31'b0, a_rv}, 32'd0);
        check("sw_rv", {31'b0, r_v}, 32'd1);
        check("sw_rdata", r_data, 32'd0);
        @(negedge clk);
        check("rv_one_cycle", {31'b0, resp_valid}, 32'd0);
        check("ready_back", {31'b0, req_ready}, 32'd1);

        xact(LW, 32'h0001_0004, 32'h0);
        check("lw_we", {31'b0, a_we}, 32'd0);
        check("lw_sel", {28'b0, a_sel}, 32'hF);
        check("lw_rv", {31'b0, r_v}, 32'd1);
        check("lw_rdata", r_data, 32'h1122_3344);

        xact(SB, 32'h0001_0009, 32'h0000_00A5);
        check("sb_sel", {28'b0, a_sel}, 32'h4);
        check("sb_addr", a_addr, 32'h0001_0008);
        check("sb_data", a_data, 32'hA5A5_A5A5);
        xact(LB, 32'h0001_0009, 32'h0);
        check("lb_rdata", r_data, 32'hFFFF_FFA5);
        xact(LBU, 32'h0001_0009, 32'h0);
        check("lbu_rdata", r_data, 32'h0000_00A5);

        xact(SH, 32'h0001_0012, 32'h0000_8001);
        check("sh_sel", {28'b0, a_sel}, 32'h3);
        check("sh_data", a_data, 32'h8001_8001);
        xact(LH, 32'h0001_0012, 32'h0);
        check("lh_rdata", r_data, 32'hFFFF_8001);
        xact(LHU, 32'h0001_0012, 32'h0);
        check("lhu_rdata", r_data, 32'h0000_8001);

        xact(LW, 32'h0001_0006, 32'h0);
        check("mis_lw_ce", {30'b0, a_ce, r_ce}, 32'd0);
        check("mis_lw_rv", {31'b0, r_v}, 32'd1);
        check("mis_lw_flags", {30'b0, r_mis, r_rng}, 32'd2);
        check("mis_lw_rdata", r_data, 32'd0);
        xact(LH, 32'h0001_0003, 32'h0);
        check("mis_lh_ce", {31'b0, a_ce}, 32'd0);
        check("mis_lh_flags", {30'b0, r_mis, r_rng}, 32'd2);

        xact(LW, 32'h0001_1000, 32'h0);
        check("rng_hi_ce", {31'b0, a_ce}, 32'd0);
        check("rng_hi_early", {31'b0, a_rv}, 32'd0);
        check("rng_hi_flags", {29'b0, r_v, r_mis, r_rng}, 32'd5);
        xact(SW, 32'h0000_FFFC, 32'hFFFF_FFFF);
        check("rng_lo_ce", {31'b0, a_ce}, 32'd0);
        check("rng_lo_flags", {29'b0, r_v, r_mis, r_rng}, 32'd5);
        xact(LH, 32'h0001_1001, 32'h0);
        check("both_flags", {29'b0, r_v, r_mis, r_rng}, 32'd7);

        xact(SW, 32'h0001_0FFC, 32'hCAFE_F00D);
        check("top_sw_ce", {31'b0, a_ce}, 32'd1);
        xact(LW, 32'h0001_0FFC, 32'h0);
        check("top_lw_flags", {29'b0, r_v, r_mis, r_rng}, 32'd4);
        check("top_lw_rdata", r_data, 32'hCAFE_F00D);

        xact(SW, 32'h0001_0020, 32'h5555_5555);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = SW;
        req_addr  = 32'h0001_0020;
        req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("rst_acc_ce_before", {31'b0, ram_ce}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_acc_ce_drop", {31'b0, ram_ce}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_acc_mem", mem[8], 32'h5555_5555);
        check("rst_acc_ready", {31'b0, req_ready}, 32'd1);
        xact(LW, 32'h0001_0020, 32'h0);
        check("rst_acc_lw", r_data, 32'h5555_5555);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator for the data RAM; sits between the MEM pipeline stage and the data RAM port.
- Accepts one load or store request at a time and drives the RAM's chip-enable, write-enable, address, byte-select and write-data pins.
- Performs big-endian byte-lane steering and load sign/zero extension.
- Checks alignment and the RAM address window; returns a one-cycle response pulse.

Parameters:
- BASE_ADDR, 32'h0001_0000, byte address of data RAM word 0 (RAM subtracts this itself).
- DEPTH_WORDS, 1024, RAM depth in 32-bit words; valid window is [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block can accept a request this cycle.
- req_op_i  in  3  operation code (see Decomposition).
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, right-justified.
- resp_valid_o  out  1  one-cycle response pulse.
- resp_rdata_o  out  32  extended load data; 0 for stores and errors.
- resp_misalign_o  out  1  alignment error, qualified by resp_valid_o.
- resp_range_o  out  1  address outside window, qualified by resp_valid_o.
- ram_ce_o  out  1  RAM chip enable (1 = enable).
- ram_we_o  out  1  RAM write enable (1 = write).
- ram_addr_o  out  32  RAM byte address, word-aligned.
- ram_sel_o  out  4  byte selects; bit3 = data[31:24].
- ram_data_o  out  32  RAM write data.
- ram_data_i  in  32  RAM read data (combinational from the RAM).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, all outputs 0 except req_ready_o=1; the request register is cleared.
- Reset during ACCESS drops ram_ce_o immediately; no write commits unless reset was already deasserted at that clock edge.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready_o=1. When req_valid_i=1 at a rising edge, register op/addr/wdata.
  - Misaligned or out of range: next state is RESP with the error flag set; the RAM is never enabled.
  - Otherwise: next state is ACCESS.
- ACCESS (exactly one cycle): ram_ce_o=1; ram_we_o=1 for stores; ram_addr_o={addr[31:2],2'b00}; ram_sel_o and ram_data_o per the lane rules below.
  - Store: commits at the closing edge.
  - Load: ram_data_i is sampled at the closing edge, extended, and stored in resp_rdata_o.
  - Next state: RESP.
- RESP: resp_valid_o=1 for exactly one cycle, with resp_rdata_o and error flags valid. req_ready_o=0. Next state: IDLE. Response outputs return to 0 in IDLE.
- Outside ACCESS, ram_ce_o=0 and ram_we_o=0; ram_addr_o, ram_sel_o and ram_data_o are 0.
- Latency: accept edge N, ACCESS in cycle N+1, resp_valid_o in cycle N+2. Throughput is one request per 3 cycles. Error responses also arrive in cycle N+2; cycle N+1 then sits in RESP-wait (no RAM activity) to keep latency uniform.
- Lane rules (big-endian; a = addr[1:0]):
  - Byte: ram_sel_o = 4'b1000 >> a; ram_data_o = {4{wdata[7:0]}}.
  - Half: a=0 -> ram_sel_o=1100; a=2 -> ram_sel_o=0011; ram_data_o = {2{wdata[15:0]}}.
  - Word: ram_sel_o=1111; ram_data_o=wdata.
  - Loads: ram_sel_o=1111. The extracted byte is ram_data_i[31-8a -: 8]; the extracted half is ram_data_i[31:16] or ram_data_i[15:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- Misaligned: half with a[0]=1; word with a!=0. Both errors can be set together.
- Range check uses full 32-bit compare; BASE_ADDR+4*DEPTH_WORDS-1 is in range and BASE_ADDR+4*DEPTH_WORDS is out of range.
- req_valid_i outside IDLE is ignored; the requester holds it until it sees req_ready_o.

Decomposition:
- Add to defines.v:
  - op codes: LB=3'b000, LBU=001, LH=010, LHU=011, LW=100, SB=101, SH=110, SW=111.
  - FSM state encodings.
  - DataMemBase constant.
- One combinational sub-module, lsu_lane_steer: op + addr[1:0] + wdata/rdata -> sel, ram write data, extended load data, misalign flag. The FSM and range check stay in the top.

Test Plan:
- SW addr 0x0001_0004, data 0x1122_3344, then LW same address: ACCESS shows ce=1, we=1, sel=1111; LW resp_rdata_o=0x1122_3344 in cycle N+2.
- SB 0xA5 at 0x0001_0009, then LB and LBU at 0x0001_0009:
  - SB: sel=0100, ram_data_o=0xA5A5_A5A5.
  - LB returns 0xFFFF_FFA5; LBU returns 0x0000_00A5.
- SH 0x8001 at 0x0001_0012, then LH/LHU: sel=0011; LH returns 0xFFFF_8001, LHU returns 0x0000_8001.
- LW at 0x0001_0006 and LH at 0x0001_0003: resp_misalign_o=1, resp_rdata_o=0, ram_ce_o never asserted.
- LW at 0x0001_1000 and SW at 0x0000_FFFC: resp_range_o=1, no RAM enable; LW at 0x0001_0FFC succeeds.
- Assert rst=0 mid-ACCESS of an SW: ram_ce_o drops immediately, the RAM word is unchanged, req_ready_o=1 after release.
